// File: rtl/timer_pkg.sv
// Shared types, BCD limits and preset sanitising for the MM:SS countdown timer.
// The optional alarm output is enabled by defining TIMER_ALARM_EN.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } timer_state_t;

  localparam logic [7:0]  SEC_MAX   = 8'h59;
  localparam logic [7:0]  MIN_MAX   = 8'h99;
  localparam logic [15:0] ZERO_TIME = 16'h0000;

  // Clamp each nibble to 9 first, so the later compare against SEC_MAX
  // can treat the byte as an ordinary binary number.
  function automatic logic [7:0] sanitise(input logic [7:0] val, input logic isSec);
    logic [3:0] hi;
    logic [3:0] lo;
    logic [7:0] res;
    hi  = (val[7:4] > 4'd9) ? 4'd9 : val[7:4];
    lo  = (val[3:0] > 4'd9) ? 4'd9 : val[3:0];
    res = {hi, lo};
    if (isSec && (res > SEC_MAX)) begin
      res = SEC_MAX;
    end else if (!isSec && (res > MIN_MAX)) begin
      res = MIN_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; wraps from 0 to MAXV and flags a borrow
// so digits can be chained from least to most significant.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [3:0] MAXV = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      digit_d = (digit_q == 4'd0) ? MAXV : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = dec & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer driven by the 1 Hz divider output.
// Define TIMER_ALARM_EN to add the timed alarm output after expiry.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int ALARM_SECS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done
`ifdef TIMER_ALARM_EN
  ,
  output logic       alarm
`endif
);

  if ((ALARM_SECS < 1) || (ALARM_SECS > 15)) begin : gBadAlarmSecs
    $error("ALARM_SECS must be in the range 1 to 15");
  end

  timer_state_t state_q;
  logic         running_q;
  logic         done_q;
  logic         sec_q;

  logic [3:0] secUnits;
  logic [3:0] secTens;
  logic [3:0] minUnits;
  logic [3:0] minTens;
  logic       secUnitsBorrow;
  logic       secTensBorrow;
  logic       minUnitsBorrow;
  logic       minTensBorrow;

  logic [7:0]  presetMin;
  logic [7:0]  presetSec;
  logic [15:0] count;
  logic        tick;
  logic        countZero;
  logic        lastSecond;
  logic        stopEff;
  logic        startEff;
  logic        decEn;

  assign tick       = sec_clk & ~sec_q;
  assign count      = {minTens, minUnits, secTens, secUnits};
  assign countZero  = (count == ZERO_TIME);
  assign lastSecond = (count == 16'h0001);
  assign presetMin  = sanitise(load_min, 1'b0);
  assign presetSec  = sanitise(load_sec, 1'b1);

  // Commands that do not apply in the current state are dropped rather than
  // masking lower-priority ones, so a start in RUN does not swallow a tick.
  assign stopEff  = stop & (state_q == RUN);
  assign startEff = start & ((state_q == IDLE) || (state_q == PAUSE)) & ~countZero;
  assign decEn    = tick & (state_q == RUN) & ~load & ~stopEff & ~countZero;

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q <= 1'b0;
    end else begin
      sec_q <= sec_clk;
    end
  end

  bcd_digit_down #(.MAXV(4'd9)) uSecUnits (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (presetSec[3:0]),
    .dec        (decEn),
    .digit      (secUnits),
    .borrow_out (secUnitsBorrow)
  );

  bcd_digit_down #(.MAXV(4'd5)) uSecTens (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (presetSec[7:4]),
    .dec        (secUnitsBorrow),
    .digit      (secTens),
    .borrow_out (secTensBorrow)
  );

  bcd_digit_down #(.MAXV(4'd9)) uMinUnits (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (presetMin[3:0]),
    .dec        (secTensBorrow),
    .digit      (minUnits),
    .borrow_out (minUnitsBorrow)
  );

  bcd_digit_down #(.MAXV(4'd9)) uMinTens (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (presetMin[7:4]),
    .dec        (minUnitsBorrow),
    .digit      (minTens),
    .borrow_out (minTensBorrow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (load) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (stopEff) begin
      state_q   <= PAUSE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (startEff) begin
      state_q   <= RUN;
      running_q <= 1'b1;
      done_q    <= 1'b0;
    end else if (decEn && lastSecond) begin
      state_q   <= EXPIRED;
      running_q <= 1'b0;
      done_q    <= 1'b1;
    end
  end

  assign min_bcd = {minTens, minUnits};
  assign sec_bcd = {secTens, secUnits};
  assign running = running_q;
  assign done    = done_q;

`ifdef TIMER_ALARM_EN
  localparam logic [3:0] ALARM_LOAD = 4'(ALARM_SECS);

  logic       alarm_q;
  logic [3:0] alarmCnt_q;

  // The counter counts expired seconds; alarm falls one clk after it empties.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      alarm_q    <= 1'b0;
      alarmCnt_q <= 4'd0;
    end else if (decEn && lastSecond) begin
      alarm_q    <= 1'b1;
      alarmCnt_q <= ALARM_LOAD;
    end else if (state_q == EXPIRED) begin
      if (tick && (alarmCnt_q != 4'd0)) begin
        alarmCnt_q <= alarmCnt_q - 4'd1;
      end
      if (alarmCnt_q == 4'd0) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign alarm = alarm_q;
`else
  logic unusedBorrow;
  assign unusedBorrow = minTensBorrow;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer against a seconds-based model.
// Build with TIMER_ALARM_EN defined to also exercise the alarm output.
module tb_bcd_countdown_timer;

`ifdef TIMER_ALARM_EN
  localparam int ALARM_SECS = 2;
`else
  localparam int ALARM_SECS = 5;
`endif

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sec_clk = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarmObs;

  int vectors = 0;
  int miscompares = 0;

  int mTotal = 0;
  int mState = S_IDLE;
  bit mSecQ = 1'b0;
  bit mAlarm = 1'b0;
  int mAlarmCnt = 0;

  always #50 clk = ~clk;

  bcd_countdown_timer #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk      (clk),
    .reset    (reset),
    .sec_clk  (sec_clk),
    .load     (load),
    .start    (start),
    .stop     (stop),
    .load_min (load_min),
    .load_sec (load_sec),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .running  (running),
    .done     (done)
`ifdef TIMER_ALARM_EN
    ,
    .alarm    (alarmObs)
`endif
  );

`ifndef TIMER_ALARM_EN
  assign alarmObs = 1'b0;
`endif

  wire [18:0] obsVec = {min_bcd, sec_bcd, running, done, alarmObs};

  function automatic logic [7:0] toBcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sanVal(input logic [7:0] v, input bit isSec);
    int tens;
    int units;
    int val;
    tens  = (int'(v[7:4]) > 9) ? 9 : int'(v[7:4]);
    units = (int'(v[3:0]) > 9) ? 9 : int'(v[3:0]);
    val   = tens * 10 + units;
    if (isSec && val > 59) val = 59;
    return val;
  endfunction

  function automatic logic expAlarm();
`ifdef TIMER_ALARM_EN
    return mAlarm;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [18:0] expVec();
    return {toBcd(mTotal / 60), toBcd(mTotal % 60), (mState == S_RUN), (mState == S_EXP), expAlarm()};
  endfunction

  // Reference behaviour: the count is a plain number of seconds.
  task automatic modelStep(input bit ld, input bit st, input bit sp, input bit sc,
                           input logic [7:0] lm, input logic [7:0] ls);
    bit tk;
    tk    = sc && !mSecQ;
    mSecQ = sc;
    if (ld) begin
      mAlarm    = 1'b0;
      mAlarmCnt = 0;
    end else if (mState == S_EXP) begin
      if (mAlarmCnt == 0) mAlarm = 1'b0;
      if (tk && mAlarmCnt > 0) mAlarmCnt--;
    end
    if (ld) begin
      mTotal = sanVal(lm, 1'b0) * 60 + sanVal(ls, 1'b1);
      mState = S_IDLE;
    end else if (sp && mState == S_RUN) begin
      mState = S_PAUSE;
    end else if (st && (mState == S_IDLE || mState == S_PAUSE) && mTotal > 0) begin
      mState = S_RUN;
    end else if (tk && mState == S_RUN && mTotal > 0) begin
      mTotal--;
      if (mTotal == 0) begin
        mState    = S_EXP;
        mAlarm    = 1'b1;
        mAlarmCnt = ALARM_SECS;
      end
    end
  endtask

  task automatic applyStimulus(input bit ld, input bit st, input bit sp, input bit sc,
                               input logic [7:0] lm, input logic [7:0] ls);
    load = ld; start = st; stop = sp; sec_clk = sc; load_min = lm; load_sec = ls;
    @(posedge clk);
    modelStep(ld, st, sp, sc, lm, ls);
    @(negedge clk);
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    load = 1'b0; start = 1'b0; stop = 1'b0;
    @(posedge clk);
    mTotal = 0; mState = S_IDLE; mSecQ = 1'b0; mAlarm = 1'b0; mAlarmCnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic loadTime(input logic [7:0] m, input logic [7:0] s);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, m, s);
  endtask

  task automatic doStart();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic doTick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    applyReset();
    vectors++;
    if (obsVec !== 19'h0) begin
      miscompares++;
      $display("[TB] FAIL reset: got %h want %h", obsVec, 19'h0);
    end
    vectors++;
    if (obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL reset model: got %h want %h", obsVec, expVec());
    end
  endtask

  task automatic test_expire();
    loadTime(8'h00, 8'h03);
    doStart();
    vectors++;
    if (running !== 1'b1 || sec_bcd !== 8'h03) begin
      miscompares++;
      $display("[TB] FAIL expire start: got run=%b sec=%h want run=1 sec=03", running, sec_bcd);
    end
    for (int i = 1; i <= 3; i++) begin
      doTick();
      vectors++;
      if (sec_bcd !== 8'(3 - i) || done !== (i == 3) || running !== (i != 3)) begin
        miscompares++;
        $display("[TB] FAIL expire step %0d: got sec=%h done=%b run=%b want sec=%h done=%b run=%b",
                 i, sec_bcd, done, running, 8'(3 - i), (i == 3), (i != 3));
      end
    end
    doTick();
    doStart();
    vectors++;
    if (obsVec !== expVec() || min_bcd !== 8'h00 || sec_bcd !== 8'h00 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL expire hold: got %h want %h", obsVec, expVec());
    end
  endtask

  task automatic test_borrow();
    loadTime(8'h01, 8'h00);
    doStart();
    doTick();
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h0059) begin
      miscompares++;
      $display("[TB] FAIL borrow 01:00: got %h:%h want 00:59", min_bcd, sec_bcd);
    end
    loadTime(8'h10, 8'h00);
    doStart();
    doTick();
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h0959 || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL borrow 10:00: got %h:%h want 09:59", min_bcd, sec_bcd);
    end
  endtask

  task automatic test_pause();
    loadTime(8'h05, 8'h30);
    doStart();
    doTick();
    doTick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      doTick();
      vectors++;
      if ({min_bcd, sec_bcd} !== 16'h0528 || running !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL pause hold %0d: got %h:%h run=%b want 05:28 run=0", i, min_bcd, sec_bcd, running);
      end
    end
    doStart();
    doTick();
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h0527 || running !== 1'b1 || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL pause resume: got %h:%h run=%b want 05:27 run=1", min_bcd, sec_bcd, running);
    end
  endtask

  task automatic test_sanitise();
    logic [7:0] m;
    logic [7:0] s;
    loadTime(8'hFA, 8'h7C);
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h9959) begin
      miscompares++;
      $display("[TB] FAIL sanitise FA:7C: got %h:%h want 99:59", min_bcd, sec_bcd);
    end
    for (int i = 0; i < 8; i++) begin
      m = 8'($urandom);
      s = 8'($urandom);
      loadTime(m, s);
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL sanitise %h:%h: got %h want %h", m, s, obsVec, expVec());
      end
    end
    loadTime(8'h00, 8'h00);
    doStart();
    vectors++;
    if (running !== 1'b0 || done !== 1'b0 || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL start at zero: got run=%b done=%b want run=0 done=0", running, done);
    end
  endtask

  task automatic test_same_cycle();
    loadTime(8'h00, 8'h10);
    doStart();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h0010 || running !== 1'b0 || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL stop+tick: got %h:%h run=%b want 00:10 run=0", min_bcd, sec_bcd, running);
    end
    loadTime(8'h00, 8'h05);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h0005 || running !== 1'b1 || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL start+tick: got %h:%h run=%b want 00:05 run=1", min_bcd, sec_bcd, running);
    end
  endtask

  task automatic test_reset_midrun();
    loadTime(8'h02, 8'h20);
    doStart();
    for (int i = 0; i < 6; i++) doTick();
    vectors++;
    if ({min_bcd, sec_bcd} !== 16'h0214 || running !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre-reset: got %h:%h run=%b want 02:14 run=1", min_bcd, sec_bcd, running);
    end
    sec_clk = 1'b1;
    applyReset();
    vectors++;
    if (obsVec !== 19'h0) begin
      miscompares++;
      $display("[TB] FAIL reset midrun: got %h want %h", obsVec, 19'h0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    vectors++;
    if (obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL after reset: got %h want %h", obsVec, expVec());
    end
  endtask

  task automatic test_random();
    bit sc;
    int hold;
    bit ld;
    bit st;
    bit sp;
    logic [7:0] lm;
    logic [7:0] ls;
    sc   = 1'b0;
    hold = 2;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        sc   = !sc;
        hold = $urandom_range(1, 4);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 399) == 0) begin
        sec_clk = sc;
        applyReset();
      end else begin
        ld = ($urandom_range(0, 39) == 0);
        st = ($urandom_range(0, 9) == 0);
        sp = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 2) == 0) begin
          lm = 8'($urandom);
          ls = 8'($urandom);
        end else begin
          lm = 8'h00;
          ls = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
        end
        applyStimulus(ld, st, sp, sc, lm, ls);
      end
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL random cycle %0d: got %h want %h", i, obsVec, expVec());
      end
    end
  endtask

`ifdef TIMER_ALARM_EN
  task automatic test_alarm();
    loadTime(8'h00, 8'h01);
    doStart();
    doTick();
    vectors++;
    if (alarmObs !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL alarm on: got alarm=%b done=%b want 1 1", alarmObs, done);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, (i % 4) < 2, 8'h00, 8'h00);
      vectors++;
      if (obsVec !== expVec() || alarmObs !== (i < 5)) begin
        miscompares++;
        $display("[TB] FAIL alarm cycle %0d: got %h want %h", i, obsVec, expVec());
      end
    end
    loadTime(8'h00, 8'h01);
    doStart();
    doTick();
    loadTime(8'h00, 8'h07);
    vectors++;
    if (alarmObs !== 1'b0 || done !== 1'b0 || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL alarm load clear: got alarm=%b done=%b want 0 0", alarmObs, done);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_expire();
    test_borrow();
    test_pause();
    test_sanitise();
    test_same_cycle();
    test_reset_midrun();
`ifdef TIMER_ALARM_EN
    test_alarm();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
